// File: rtl/ntt_stage_ctrl.sv
// Stage/butterfly sequencer for the 512-point radix-2 NTT/INTT core.
// Define NTT_STAGE_CTRL_PERF_EN to add the cycle_cnt performance counter.
module ntt_stage_ctrl #(
  parameter int LOGN       = 9,
  parameter int BF_LATENCY = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            inverse,
  output logic            busy,
  output logic            done,
  output logic [LOGN-6:0] stage,
  output logic            bf_inv,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
`ifdef NTT_STAGE_CTRL_PERF_EN
  ,
  output logic [15:0]     cycle_cnt
`endif
);

  localparam int SW = LOGN - 5;
  localparam int JW = LOGN - 1;
  localparam int DW = 2 * LOGN + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [SW-1:0] LAST = SW'(LOGN - 1);
  localparam logic [JW-1:0] JMAX = '1;
  localparam logic [3:0]    DMAX = 4'(BF_LATENCY - 1);

  logic [1:0]    state;
  logic [JW-1:0] j;
  logic [3:0]    dcnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      stage  <= '0;
      j      <= '0;
      dcnt   <= '0;
      bf_inv <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bf_inv <= inverse;
            stage  <= '0;
            j      <= '0;
            dcnt   <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          j <= j + JW'(1);
          if (j == JMAX) begin
            dcnt  <= '0;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          dcnt <= dcnt + 4'd1;
          if (dcnt == DMAX) begin
            dcnt <= '0;
            if (stage == LAST) begin
              state <= S_DONE;
            end else begin
              stage <= stage + SW'(1);
              state <= S_RUN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_en = (state == S_RUN);
  assign busy  = (state == S_RUN) || (state == S_DRAIN);
  assign done  = (state == S_DONE);

  // Half-span is a power of two, so group/offset split is a shift and mask.
  logic [SW-1:0]   rs, sh, sh1;
  logic [LOGN-1:0] jx, hh, g, k, a, b, tw;

  always_comb begin
    rs  = LAST - stage;
    sh  = bf_inv ? stage : rs;
    sh1 = sh + SW'(1);
    jx  = {1'b0, j};
    hh  = LOGN'(1) << sh;
    g   = jx >> sh;
    k   = jx & (hh - LOGN'(1));
    a   = (g << sh1) | k;
    b   = a + hh;
    tw  = (LOGN'(1) << (bf_inv ? rs : stage)) + g;
  end

  assign rd_addr_a = rd_en ? a  : '0;
  assign rd_addr_b = rd_en ? b  : '0;
  assign tw_addr   = rd_en ? tw : '0;

  logic [DW-1:0] dl [BF_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BF_LATENCY; i++) dl[i] <= '0;
    end else begin
      dl[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int i = 1; i < BF_LATENCY; i++) dl[i] <= dl[i-1];
    end
  end

  assign {wr_en, wr_addr_a, wr_addr_b} = dl[BF_LATENCY-1];

`ifdef NTT_STAGE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst)
      cycle_cnt <= '0;
    else if (state == S_IDLE && start)
      cycle_cnt <= '0;
    else if (busy)
      cycle_cnt <= cycle_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Directed bench for ntt_stage_ctrl: schedule, write alignment,
// stage timing, start handling and reset mid-transform.
module tb_ntt_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       inverse = 1'b0;
  logic       busy, done, bf_inv, rd_en, wr_en;
  logic [3:0] stage;
  logic [8:0] rd_addr_a, rd_addr_b, tw_addr;
  logic [8:0] wr_addr_a, wr_addr_b;
`ifdef NTT_STAGE_CTRL_PERF_EN
  logic [15:0] cycle_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  logic [8:0] oa [0:3300];
  logic [8:0] ob [0:3300];
  logic [8:0] ot [0:3300];
  logic       orr [0:3300];
  logic       obsy [0:3300];
  logic       odn [0:3300];
  int         wcnt [9];

  always #5 clk = ~clk;

  ntt_stage_ctrl dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .inverse(inverse),
    .busy(busy),
    .done(done),
    .stage(stage),
    .bf_inv(bf_inv),
    .rd_en(rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_addr(tw_addr),
    .wr_en(wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b)
`ifdef NTT_STAGE_CTRL_PERF_EN
    ,
    .cycle_cnt(cycle_cnt)
`endif
  );

  typedef struct packed {
    logic       rd;
    logic [8:0] a;
    logic [8:0] b;
    logic [8:0] tw;
    logic       busy;
    logic       done;
    logic [3:0] st;
    logic       inv;
  } exp_t;

  // Reference schedule: cycle c counted from the start-accept cycle 0.
  function automatic exp_t model(input int c, input int base2,
                                 input bit inv);
    exp_t e;
    int t, s, r, h, g, k;
    e = '0;
    t = (base2 > 0 && c >= base2) ? c - base2 : c - 1;
    if (t < 0 || t > 2376) return e;
    e.inv = inv;
    if (t == 2376) begin
      e.done = 1'b1;
      e.st   = 4'd8;
      return e;
    end
    s = t / 264;
    r = t % 264;
    e.busy = 1'b1;
    e.st = 4'(s);
    if (r < 256) begin
      e.rd = 1'b1;
      h = inv ? (1 << s) : (512 >> (s + 1));
      g = r / h;
      k = r % h;
      e.a = 9'(2 * h * g + k);
      e.b = 9'(2 * h * g + k + h);
      e.tw = inv ? 9'((512 >> (s + 1)) + g) : 9'((1 << s) + g);
    end
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({busy, done, stage, bf_inv, rd_en, rd_addr_a, rd_addr_b,
         tw_addr, wr_en, wr_addr_a, wr_addr_b} !== 54'd0) begin
      errs++;
      $display("FAIL reset_outputs: got busy=%b rd=%b wr=%b stage=%0d want all 0",
               busy, rd_en, wr_en, stage);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({busy, done, rd_en, wr_en} !== 4'b0) begin
      errs++;
      $display("FAIL reset_idle: got busy=%b done=%b rd=%b wr=%b want 0000",
               busy, done, rd_en, wr_en);
    end
  endtask

  task automatic test_transform(input bit inv, input bit bnd);
    int   last, idx, b2;
    exp_t e, ew;
    logic m;
    logic [34:0] obs;
    bit   bad_c, bad_w;
    bad_c = 1'b0;
    bad_w = 1'b0;
    last = bnd ? 3271 : 2385;
    b2 = bnd ? 2379 : 0;
    for (int s = 0; s < 9; s++) wcnt[s] = 0;
    @(negedge clk);
    start = 1'b1;
    inverse = inv;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      e  = model(c, b2, inv);
      ew = model(c - 8, b2, inv);
      m  = e.busy | e.done;
      obs = {rd_en, rd_addr_a, rd_addr_b, tw_addr, busy, done,
             m ? stage : 4'd0, m ? bf_inv : 1'b0};
      oa[c] = rd_addr_a;
      ob[c] = rd_addr_b;
      ot[c] = tw_addr;
      orr[c] = rd_en;
      obsy[c] = busy;
      odn[c] = done;
      if (wr_en === 1'b1 && c >= 9 && c <= 2377) begin
        idx = (c - 9) / 264;
        if (idx < 9) wcnt[idx]++;
      end
      if (!bad_c) begin
        vecs++;
        if (obs !== e) begin
          errs++;
          bad_c = 1'b1;
          $display("FAIL ctrl cycle %0d: got %h want %h", c, obs, e);
        end
      end
      if (!bad_w) begin
        vecs++;
        if ({wr_en, wr_addr_a, wr_addr_b} !== {ew.rd, ew.a, ew.b}) begin
          errs++;
          bad_w = 1'b1;
          $display("FAIL wr_align cycle %0d: got %b/%0d/%0d want %b/%0d/%0d",
                   c, wr_en, wr_addr_a, wr_addr_b, ew.rd, ew.a, ew.b);
        end
      end
`ifdef NTT_STAGE_CTRL_PERF_EN
      if (!bnd && (c == 2377 || c == 2385)) begin
        vecs++;
        if (cycle_cnt !== 16'd2376) begin
          errs++;
          $display("FAIL cycle_cnt cycle %0d: got %0d want 2376", c, cycle_cnt);
        end
      end
`endif
      start = bnd ? (c == 500 || (c >= 2370 && c <= 2380)) : 1'b0;
      if (bnd && c == 600) inverse = 1'b0;
      if (bnd && c == 2000) inverse = 1'b1;
    end
  endtask

  task automatic test_forward;
    int pc [4] = '{1, 2, 256, 2118};
    logic [26:0] ev [4] = '{{9'd0, 9'd256, 9'd1}, {9'd1, 9'd257, 9'd1},
                            {9'd255, 9'd511, 9'd1}, {9'd10, 9'd11, 9'd261}};
    int lo, tot;
    test_transform(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if ({oa[pc[i]], ob[pc[i]], ot[pc[i]]} !== ev[i]) begin
        errs++;
        $display("FAIL fwd_addr cycle %0d: got %0d/%0d/%0d want %h",
                 pc[i], oa[pc[i]], ob[pc[i]], ot[pc[i]], ev[i]);
      end
    end
    vecs++;
    if (obsy[1] !== 1'b1) begin
      errs++;
      $display("FAIL busy_rise: got %b want 1", obsy[1]);
    end
    vecs++;
    if ({odn[2376], odn[2377], obsy[2377], odn[2378]} !== 4'b0100) begin
      errs++;
      $display("FAIL done_timing: got %b%b%b%b want 0100",
               odn[2376], odn[2377], obsy[2377], odn[2378]);
    end
    lo = 0;
    for (int c = 257; c <= 264; c++) if (orr[c] === 1'b0) lo++;
    vecs++;
    if (lo !== 8 || orr[256] !== 1'b1 || orr[265] !== 1'b1) begin
      errs++;
      $display("FAIL drain_gap: got %0d low cycles want 8", lo);
    end
    tot = 0;
    for (int s = 0; s < 9; s++) begin
      tot += wcnt[s];
      vecs++;
      if (wcnt[s] !== 256) begin
        errs++;
        $display("FAIL wr_per_stage %0d: got %0d want 256", s, wcnt[s]);
      end
    end
    vecs++;
    if (tot !== 2304) begin
      errs++;
      $display("FAIL wr_total: got %0d want 2304", tot);
    end
  endtask

  task automatic test_inverse_boundaries;
    int dn;
    test_transform(1'b1, 1'b1);
    vecs++;
    if ({oa[4], ob[4], ot[4]} !== {9'd6, 9'd7, 9'd259}) begin
      errs++;
      $display("FAIL inv_s0_j3: got %0d/%0d/%0d want 6/7/259",
               oa[4], ob[4], ot[4]);
    end
    vecs++;
    if ({oa[2120], ob[2120], ot[2120]} !== {9'd7, 9'd263, 9'd1}) begin
      errs++;
      $display("FAIL inv_s8_j7: got %0d/%0d/%0d want 7/263/1",
               oa[2120], ob[2120], ot[2120]);
    end
    vecs++;
    if ({orr[2378], obsy[2378], orr[2379]} !== 3'b001) begin
      errs++;
      $display("FAIL restart_timing: got rd=%b busy=%b rd_next=%b want 0 0 1",
               orr[2378], obsy[2378], orr[2379]);
    end
    vecs++;
    if ({oa[2379], ob[2379], ot[2379]} !== {9'd0, 9'd1, 9'd256}) begin
      errs++;
      $display("FAIL restart_addr: got %0d/%0d/%0d want 0/1/256",
               oa[2379], ob[2379], ot[2379]);
    end
    dn = 0;
    for (int c = 1; c <= 2378; c++) if (odn[c] === 1'b1) dn++;
    vecs++;
    if (dn !== 1) begin
      errs++;
      $display("FAIL done_count: got %0d want 1", dn);
    end
  endtask

  task automatic test_reset_mid;
    int nw, nr, nb;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    vecs++;
    if ({busy, done, stage, bf_inv, rd_en, rd_addr_a, rd_addr_b,
         tw_addr, wr_en, wr_addr_a, wr_addr_b} !== 54'd0) begin
      errs++;
      $display("FAIL reset_mid_outputs: got busy=%b rd=%b wr=%b stage=%0d want all 0",
               busy, rd_en, wr_en, stage);
    end
    rst = 1'b1;
    nw = 0;
    nr = 0;
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wr_en !== 1'b0) nw++;
      if (rd_en !== 1'b0) nr++;
      if (busy !== 1'b0) nb++;
    end
    vecs++;
    if (nw !== 0 || nr !== 0 || nb !== 0) begin
      errs++;
      $display("FAIL reset_mid_quiet: got wr=%0d rd=%0d busy=%0d want 0",
               nw, nr, nb);
    end
  endtask

  initial begin
    test_reset;
    test_inverse_boundaries;
    test_reset_mid;
    test_forward;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
